// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master
// Single-outstanding AXI4-Lite master. It turns a cmd/rsp handshake into one
// AXI-Lite register read or write. A watchdog turns a hung slave into an
// error response, so the issuing logic cannot deadlock.
module axi_lite_cmd_master #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         ADDR_WIDTH     = 32,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [2:0] AXI_PROT       = 3'b000
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,

  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp
);

  // The counter must be able to hold TIMEOUT_CYCLES. When the watchdog is disabled,
  // it keeps a single bit so that no zero-width vector is declared.
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WD_EN    = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             busy;
  logic             wd_fire;
  logic             aw_ok;
  logic             w_ok;

  assign cmd_ready    = (state == IDLE);
  assign m_axi_bready = (state == WRESP);
  assign m_axi_rready = (state == RDATA);
  assign m_axi_awprot = AXI_PROT;
  assign m_axi_arprot = AXI_PROT;

  assign busy    = (state == WADDR) || (state == WRESP) || (state == RADDR) || (state == RDATA);
  assign wd_fire = WD_EN && busy && (wd_cnt == WD_LIMIT);

  // A channel counts as done when it is no longer pending or its handshake occurs this cycle.
  assign aw_ok = !m_axi_awvalid || m_axi_awready;
  assign w_ok  = !m_axi_wvalid  || m_axi_wready;

  // Transaction FSM. It registers every AXI valid, every payload and every response field,
  // and runs the watchdog. If the watchdog fires in the same cycle as a slave handshake,
  // the watchdog takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wd_cnt        <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      rsp_timeout   <= 1'b0;
    end else begin
      if (busy && (wd_cnt != '1)) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end

      if (wd_fire) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        state         <= RESP;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              wd_cnt      <= '0;
              rsp_timeout <= 1'b0;
              if (cmd_write) begin
                m_axi_awaddr  <= cmd_addr;
                m_axi_wdata   <= cmd_wdata;
                m_axi_wstrb   <= cmd_wstrb;
                m_axi_awvalid <= 1'b1;
                m_axi_wvalid  <= 1'b1;
                state         <= WADDR;
              end else begin
                m_axi_araddr  <= cmd_addr;
                m_axi_arvalid <= 1'b1;
                state         <= RADDR;
              end
            end
          end
          WADDR: begin
            if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
            if (aw_ok && w_ok) state <= WRESP;
          end
          WRESP: begin
            if (m_axi_bvalid) begin
              rsp_resp    <= m_axi_bresp;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
          RADDR: begin
            if (m_axi_arready) begin
              m_axi_arvalid <= 1'b0;
              state         <= RDATA;
            end
          end
          RDATA: begin
            if (m_axi_rvalid) begin
              rsp_rdata   <= m_axi_rdata;
              rsp_resp    <= m_axi_rresp;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end
          end
          RESP: begin
            if (rsp_ready) begin
              rsp_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master
// Directed and randomized transactions against axi_lite_cmd_master. A small
// AXI-Lite slave built into the stimulus task supplies the bus side.
// Expected responses come from the slave delays and the transaction rules.
module tb_axi_lite_cmd_master;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  int checks = 0;
  int errors = 0;
  int n;
  int busyIssued;

  axi_lite_cmd_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO), .AXI_PROT(3'b000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic slaveIdle();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    m_axi_bresp   = 2'b00;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = 32'h0;
    m_axi_rresp   = 2'b00;
  endtask

  // Issues one command. The slave waits the given number of cycles before each handshake.
  // A delay of 1000 means a channel that never completes.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, input int awDly, input int wDly,
                               input logic wAfterAw, input int bDly, input int arDly, input int rDly,
                               input logic [31:0] sdata, input logic [1:0] sresp, input int rspHold);
    int awC, wC, bothC, arC, finalC, expRspCyc;
    logic expTo;
    logic [31:0] expRdata;
    logic [1:0] expResp;
    int cyc, awHs, wHs, bHs, arHs, rHs, awHsCyc, wHsCyc, arHsCyc, bothSeen;
    int rspCyc, payErr, wrongCh, unstable;
    logic rspSeen;
    logic [31:0] snapRdata;
    logic [1:0] snapResp;
    logic snapTo;

    // Predict the handshake cycles. Cycle 1 is the first cycle after the command is accepted.
    awC      = awDly + 1;
    wC       = wAfterAw ? (awC + wDly + 1) : (wDly + 1);
    bothC    = (awC > wC) ? awC : wC;
    arC      = arDly + 1;
    finalC   = wr ? (bothC + bDly + 1) : (arC + rDly + 1);
    expTo    = (finalC >= TO + 1);
    expRspCyc = expTo ? (TO + 2) : (finalC + 1);
    expRdata = (expTo || wr) ? 32'h0 : sdata;
    expResp  = expTo ? 2'b10 : sresp;

    @(negedge clk);
    checkOutput("cmd_ready before cmd", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    cyc = 1; awHs = 0; wHs = 0; bHs = 0; arHs = 0; rHs = 0;
    awHsCyc = 0; wHsCyc = 0; arHsCyc = 0; bothSeen = 0;
    rspCyc = 0; payErr = 0; wrongCh = 0; unstable = 0; rspSeen = 1'b0;
    checkOutput("first valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}),
                64'(wr ? 3'b110 : 3'b001));

    while (!rspSeen && cyc <= 60) begin
      if (rsp_valid) begin
        rspSeen = 1'b1;
        rspCyc  = cyc;
      end else begin
        if ((wr && m_axi_arvalid) || (!wr && (m_axi_awvalid || m_axi_wvalid))) wrongCh++;
        if (m_axi_awvalid && (m_axi_awaddr !== addr)) payErr++;
        if (m_axi_wvalid && ((m_axi_wdata !== wd) || (m_axi_wstrb !== strb))) payErr++;
        if (m_axi_arvalid && (m_axi_araddr !== addr)) payErr++;
        m_axi_bvalid  = (awHs > 0) && (wHs > 0) && (bHs == 0) && (cyc > bothSeen + bDly);
        m_axi_bresp   = sresp;
        m_axi_rvalid  = (arHs > 0) && (rHs == 0) && (cyc > arHsCyc + rDly);
        m_axi_rdata   = sdata;
        m_axi_rresp   = sresp;
        m_axi_awready = (cyc > awDly);
        m_axi_wready  = wAfterAw ? ((awHs > 0) && (cyc > awHsCyc + wDly)) : (cyc > wDly);
        m_axi_arready = (cyc > arDly);
        if (m_axi_awvalid && m_axi_awready) begin if (awHs == 0) awHsCyc = cyc; awHs++; end
        if (m_axi_wvalid && m_axi_wready)   begin if (wHs == 0) wHsCyc = cyc; wHs++; end
        if (m_axi_arvalid && m_axi_arready) begin if (arHs == 0) arHsCyc = cyc; arHs++; end
        if (m_axi_bvalid && m_axi_bready) bHs++;
        if (m_axi_rvalid && m_axi_rready) rHs++;
        bothSeen = (awHsCyc > wHsCyc) ? awHsCyc : wHsCyc;
        @(negedge clk);
        cyc++;
      end
    end
    slaveIdle();

    if (!rspSeen) begin
      checkOutput("rsp_valid within bound", 64'(rsp_valid), 64'(1));
    end else begin
      checkOutput("rsp latency", 64'(rspCyc), 64'(expRspCyc));
      checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(expRdata));
      checkOutput("rsp_resp", 64'(rsp_resp), 64'(expResp));
      checkOutput("rsp_timeout", 64'(rsp_timeout), 64'(expTo));
      checkOutput("bus idle in resp",
                  64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
      checkOutput("wrong channel activity", 64'(wrongCh), 64'(0));
      if (!expTo) begin
        checkOutput("payload", 64'(payErr), 64'(0));
        if (wr) begin
          checkOutput("aw/w/b handshakes", 64'({awHs[7:0], wHs[7:0], bHs[7:0]}), 64'(24'h010101));
          checkOutput("aw/w handshake cycles", 64'({awHsCyc[15:0], wHsCyc[15:0]}),
                      64'({awC[15:0], wC[15:0]}));
        end else begin
          checkOutput("ar/r handshakes", 64'({arHs[7:0], rHs[7:0]}), 64'(16'h0101));
          checkOutput("ar handshake cycle", 64'(arHsCyc), 64'(arC));
        end
      end
    end

    snapRdata = rsp_rdata; snapResp = rsp_resp; snapTo = rsp_timeout;
    repeat (rspHold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== snapRdata || rsp_resp !== snapResp || rsp_timeout !== snapTo)
        unstable++;
    end
    checkOutput("rsp stable while held", 64'(unstable), 64'(0));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rsp released", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
  endtask

  // Main directed sequence.
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
    cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
    slaveIdle();
    #3;
    checkOutput("rst valids/readies",
                64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}), 64'(0));
    checkOutput("rst cmd_ready", 64'(cmd_ready), 64'(1));
    checkOutput("rst addresses", 64'({m_axi_awaddr, m_axi_araddr}), 64'(0));
    checkOutput("rst wdata/wstrb", 64'({m_axi_wdata, m_axi_wstrb}), 64'(0));
    checkOutput("rst prot", 64'({m_axi_awprot, m_axi_arprot}), 64'(0));
    checkOutput("rst rsp fields", 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write, always-ready slave");
    applyStimulus(1'b1, 32'h38, 32'h1, 4'hF, 0, 0, 1'b0, 0, 0, 0, 32'h0, 2'b00, 0);
    $display("[TB] write, wready after AW, late bvalid");
    applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 1, 1, 1'b1, 2, 0, 0, 32'h0, 2'b00, 1);
    $display("[TB] read with wait states, held response");
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 1'b0, 0, 0, 2, 32'h12345678, 2'b00, 5);
    $display("[TB] read SLVERR pass-through");
    applyStimulus(1'b0, 32'h2C, 32'h0, 4'h0, 0, 0, 1'b0, 0, 1, 1, 32'h5A5AA5A5, 2'b10, 1);
    $display("[TB] read timeout, arready stuck");
    applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, 0, 0, 1'b0, 0, 1000, 0, 32'h0, 2'b00, 2);
    $display("[TB] write timeout, bvalid stuck");
    applyStimulus(1'b1, 32'h48, 32'h0BADF00D, 4'hF, 0, 0, 1'b0, 1000, 0, 0, 32'h0, 2'b00, 1);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

    $display("[TB] reset in WRESP with busy-time command");
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h80; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'h3;
    @(negedge clk);
    cmd_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    n = 0;
    while (!m_axi_bready && n < 10) begin
      @(negedge clk);
      n++;
    end
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    checkOutput("reached WRESP", 64'(m_axi_bready), 64'(1));
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("busy cmd not accepted",
                64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, cmd_ready, m_axi_bready}), 64'(5'b00001));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async reset clears bus",
                64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    busyIssued = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) busyIssued++;
    end
    checkOutput("busy cmd never issued", 64'(busyIssued), 64'(0));
    checkOutput("cmd_ready after release", 64'(cmd_ready), 64'(1));

    $display("[TB] reset with arvalid on the bus");
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("arvalid before reset", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, 32'h24}));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arvalid async clear", 64'({m_axi_arvalid, m_axi_araddr}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] read after reset recovery");
    applyStimulus(1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 1'b0, 0, 2, 1, 32'hA5A5_0F0F, 2'b01, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple command/response handshake into AXI-Lite register reads and writes. It is the initiator counterpart to the action's AXI-Lite global and kernel register slaves, used by a host-side bench driver and by on-chip managers that poke kernel control registers. A watchdog timeout converts a hung slave into an error response so the issuing logic never deadlocks.

## Interface
- DATA_WIDTH, 32, AXI data width; only 32 is supported, with 4 strobe bits.
- ADDR_WIDTH, 32, AXI address width.
- TIMEOUT_CYCLES, 1024, maximum busy cycles per transaction; 0 disables the watchdog.
- AXI_PROT, 3'b000, constant driven on awprot/arprot.

Ports:
- clk  in  1  single clock; every flop is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  register byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and on timeout.
- rsp_resp  out  2  captured bresp/rresp; 2'b10 on timeout.
- rsp_timeout  out  1  the watchdog expired.
- m_axi_awvalid/awready/awaddr/awprot, m_axi_wvalid/wready/wdata/wstrb, m_axi_bvalid/bready/bresp, m_axi_arvalid/arready/araddr/arprot, m_axi_rvalid/rready/rdata/rresp: the standard AXI4-Lite master directions and widths.

## Operation
- States: IDLE, WADDR (AW and W pending), WRESP, RADDR, RDATA, RESP.
- IDLE: a cmd_valid & cmd_ready handshake latches addr, wdata, wstrb and write. Next state is WADDR for a write, RADDR for a read.
- WADDR:
  - awvalid and wvalid are asserted together.
  - Each one drops independently on its own handshake.
  - awready and wready in the same cycle completes both.
  - Move to WRESP once both handshakes are done. A slave that asserts wready only after the AW handshake must work.
- WRESP: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0 and go to RESP.
- RADDR: arvalid = 1 until arready, then go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata and rresp and go to RESP.
- RESP: rsp_valid = 1 until rsp_ready, then go to IDLE. Response fields are stable while rsp_valid is high.
- Watchdog:
  - The counter clears on command accept and increments every cycle in WADDR, WRESP, RADDR and RDATA.
  - When it reaches TIMEOUT_CYCLES, the block drops every AXI valid and ready, sets rsp_timeout = 1, rsp_resp = 2'b10 and rsp_rdata = 0, then goes to RESP.
  - The abandoned transaction is not retried. Recovery of the slave needs rst_n.
- Commands presented while busy are ignored because cmd_ready is low. There is no queueing.
- bresp and rresp values other than OKAY are passed through unchanged with rsp_timeout = 0.

## Timing
- Reset values:
  - State IDLE; cmd_ready = 1.
  - All m_axi valids and readies 0; awaddr, araddr, wdata, wstrb 0; prot = AXI_PROT.
  - rsp_valid 0, rsp_rdata 0, rsp_resp 0, rsp_timeout 0; watchdog 0.
- Assertion of rst_n mid-transaction clears everything asynchronously to the values above, including any valid already on the bus.
- All AXI valid and address/data outputs are registered. bready, rready and cmd_ready may be decoded from the state register.
- A command accepted at edge N gives awvalid/wvalid (or arvalid) high in cycle N+1.
- After the final slave handshake at edge M, rsp_valid is high in cycle M+1.
- Valid stability: once asserted, awvalid, wvalid and arvalid and their payloads hold until their handshake or a timeout.
- cmd_ready returns high the cycle after the rsp handshake, so back-to-back commands are spaced by at least one IDLE cycle.
- The watchdog fires on the cycle the count equals TIMEOUT_CYCLES. rsp_valid is high the following cycle.
- Counter width is clog2(TIMEOUT_CYCLES+1) and it saturates with no wrap.

## Test plan
- Write with an always-ready slave: cmd write addr 0x38, data 0x1, strb 0xF → AW and W accepted in the same cycle, bresp OKAY, rsp_resp 0, rsp_rdata 0, rsp_timeout 0.
- Write to a slave that raises wready only after the AW handshake, with bvalid 3 cycles later: addr 0x40, data 0xDEADBEEF → wvalid held until wready; exactly one AW and one W handshake; a single rsp.
- Read of addr 0x10 with the slave returning 0x12345678 and rresp 2'b00 after 2 wait cycles → rsp_rdata 0x12345678, rsp_resp 0. Hold rsp_ready low for 5 cycles → rsp stays stable.
- SLVERR pass-through: slave returns rresp 2'b10 with data 0x5A5AA5A5 → rsp_resp 2'b10, rsp_rdata 0x5A5AA5A5, rsp_timeout 0.
- Timeout with TIMEOUT_CYCLES = 16 and arready stuck low → arvalid drops and rsp_valid rises with rsp_timeout 1, rsp_resp 2'b10, rsp_rdata 0; cmd_ready returns after rsp_ready.
- Reset in WRESP, plus a cmd_valid pulse while busy → the busy-time command is never issued on AXI; after rst_n low, all valids are 0 immediately and cmd_ready = 1 after release.
